// File: rtl/mul8x16_seq.sv
`timescale 1ns / 1ps
// Sequential signed 8x16 multiplier: radix-2 shift-add on operand magnitudes, sign fixed at the end.
// Launches on a falling edge of start; 17-cycle fixed latency from the launch edge.
module mul8x16_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [15:0] b,
   output logic [23:0] p,
   output logic        done,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

   state_e      r_state;
   state_e      w_state_d;
   logic        r_start_q;
   logic [8:0]  r_mag_a;
   logic [15:0] r_mag_b;
   logic        r_sign;
   logic [23:0] r_acc;
   logic [3:0]  r_cnt;
   logic [23:0] r_p;
   logic        r_done;

   logic        w_launch;
   logic [8:0]  w_a_ext;
   logic [8:0]  w_abs_a;
   logic [15:0] w_abs_b;
   logic [23:0] w_addend;

   // 9-bit magnitude so that |-128| = 128 is representable
   assign w_a_ext  = {a[7], a};
   assign w_abs_a  = a[7] ? (~w_a_ext + 9'd1) : w_a_ext;
   assign w_abs_b  = b[15] ? (~b + 16'd1) : b;
   assign w_addend = {15'd0, r_mag_a} << r_cnt;

   assign w_launch = r_start_q & ~start & ((r_state == StIdle) | (r_state == StDone));

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle:  if (w_launch) w_state_d = StRun;
         StRun:   if (r_cnt == 4'd15) w_state_d = StFix;
         StFix:   w_state_d = StDone;
         StDone: begin
            if (w_launch) begin
               w_state_d = StRun;
            end else if (start) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= StIdle;
         r_start_q <= 1'b0;
         r_mag_a   <= 9'd0;
         r_mag_b   <= 16'd0;
         r_sign    <= 1'b0;
         r_acc     <= 24'd0;
         r_cnt     <= 4'd0;
         r_p       <= 24'd0;
         r_done    <= 1'b0;
      end else begin
         r_start_q <= start;
         r_state   <= w_state_d;
         if (w_launch) begin
            r_mag_a <= w_abs_a;
            r_mag_b <= w_abs_b;
            r_sign  <= a[7] ^ b[15];
            r_acc   <= 24'd0;
            r_cnt   <= 4'd0;
            r_done  <= 1'b0;
         end else if (r_state == StRun) begin
            if (r_mag_b[r_cnt]) begin
               r_acc <= r_acc + w_addend;
            end
            r_cnt <= r_cnt + 4'd1;
         end else if (r_state == StFix) begin
            r_p    <= r_sign ? (~r_acc + 24'd1) : r_acc;
            r_done <= 1'b1;
         end
      end
   end

   assign p    = r_p;
   assign done = r_done;
   assign busy = (r_state == StRun) | (r_state == StFix);

endmodule
